np_fm_pingpong_buffer: RTL and testbench

//  Ping-pong feature-map buffer directly upstream of the FFN matrix-mult controller.

---
 rtl/np_fm_pingpong_buffer_if.sv | 54 +++++
 rtl/np_fm_pingpong_buffer.sv | 116 +++++++++++
 tb/tb_np_fm_pingpong_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/np_fm_pingpong_buffer_if.sv
// ----------------------------------------------------------------------------
// np_fm_pingpong_buffer_if
//   Bundles the upstream word stream and the matrix-mult controller read port
//   of the ping-pong feature-map buffer.
//
//   Signals
//     in_valid     upstream word valid             (master -> slave)
//     in_data      upstream feature-map word       (master -> slave)
//     in_ready     buffer can accept a word        (slave  -> master)
//     rd_addr      controller read address         (master -> slave)
//     rd_data      registered read data            (slave  -> master)
//     buffer_rdy   a full bank is being served     (slave  -> master)
//     product_rdy  controller finished the bank    (master -> slave)
//     full_banks   number of full banks, 0..2      (slave  -> master)
//
//   Modports
//     master  upstream producer + controller side
//     slave   the buffer itself
// ----------------------------------------------------------------------------
interface np_fm_pingpong_buffer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 7
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              buffer_rdy;
    logic              product_rdy;
    logic [1:0]        full_banks;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        output rd_addr,
        input  rd_data,
        input  buffer_rdy,
        output product_rdy,
        input  full_banks
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        input  rd_addr,
        output rd_data,
        output buffer_rdy,
        input  product_rdy,
        output full_banks
    );
endinterface

// File: rtl/np_fm_pingpong_buffer.sv
// ----------------------------------------------------------------------------
// np_fm_pingpong_buffer
//   Ping-pong feature-map buffer feeding the FFN matrix-mult controller.
//   Words from the conv stage fill one DEPTH-word bank while the controller
//   reads the other. A full bank is announced with buffer_rdy and served by
//   rd_addr until the controller pulses product_rdy, which frees the bank.
//
//   Ports
//     clock        system clock, rising edge
//     reset        asynchronous, active-low
//     bus (slave)  in_valid/in_data/in_ready  upstream word stream
//                  rd_addr/rd_data            controller read port (1-cycle)
//                  buffer_rdy/product_rdy     bank handoff with the controller
//                  full_banks                 full bank count (status)
// ----------------------------------------------------------------------------
module np_fm_pingpong_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    np_fm_pingpong_buffer_if.slave bus
);

    localparam int unsigned       PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(DEPTH);

    // Storage: two banks, never cleared by reset.
    logic [DATA_W-1:0] r_mem [2][DEPTH];

    // Control state
    logic              r_wb;          // bank being written
    logic              r_rb;          // bank being served to the controller
    logic [PTR_W-1:0]  r_wptr;        // next write slot in r_wb
    logic [1:0]        r_full_cnt;    // full banks, 0..2
    logic              r_buffer_rdy;
    logic [DATA_W-1:0] r_rd_data;

    // Combinational helpers
    logic              w_in_ready;
    logic              w_accept;
    logic              w_complete;
    logic              w_release;
    logic [1:0]        w_full_cnt_next;
    logic              w_rd_in_range;
    logic [PTR_W-1:0]  w_rd_idx;

    // Input stalls only when both banks hold unreleased data, so a word is
    // never written over a bank the controller still owns.
    assign w_in_ready = (r_full_cnt != 2'd2);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_complete = w_accept & (r_wptr == LAST_PTR);
    assign w_release  = bus.product_rdy & r_buffer_rdy;

    assign w_rd_in_range = (bus.rd_addr < DEPTH_ADDR);
    assign w_rd_idx      = bus.rd_addr[PTR_W-1:0];

    // Completion and release in the same cycle cancel in the count.
    always_comb begin
        w_full_cnt_next = r_full_cnt;
        if (w_complete && !w_release) begin
            w_full_cnt_next = r_full_cnt + 2'd1;
        end else if (!w_complete && w_release) begin
            w_full_cnt_next = r_full_cnt - 2'd1;
        end
    end

    // Bank write port
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_wb][r_wptr] <= bus.in_data;
        end
    end

    // Pointers, count and handshake flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
            r_wptr       <= '0;
            r_full_cnt   <= 2'd0;
            r_buffer_rdy <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= w_complete ? '0 : r_wptr + 1'b1;
            end
            if (w_complete) begin
                r_wb <= ~r_wb;
            end
            if (w_release) begin
                r_rb <= ~r_rb;
            end
            r_full_cnt <= w_full_cnt_next;
            // Forced low for one cycle after a release so the controller
            // restarts its address at 0 before the next bank is offered.
            r_buffer_rdy <= w_release ? 1'b0 : (w_full_cnt_next != 2'd0);
        end
    end

    // Registered read port; out-of-range addresses (controller overrun) read 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_in_range ? r_mem[r_rb][w_rd_idx] : '0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.rd_data    = r_rd_data;
    assign bus.buffer_rdy = r_buffer_rdy;
    assign bus.full_banks = r_full_cnt;

endmodule

// File: tb/tb_np_fm_pingpong_buffer.sv
// ----------------------------------------------------------------------------
// tb_np_fm_pingpong_buffer
//   Directed bench for the ping-pong feature-map buffer. Inputs change #1
//   after the rising edge; outputs are sampled at that same point, i.e. they
//   show the effect of the edge just taken.
// ----------------------------------------------------------------------------
module tb_np_fm_pingpong_buffer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 7;

    logic clock;
    logic reset;

    int n_tests;
    int n_fail;

    np_fm_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    np_fm_pingpong_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one word and holds it until accepted (bounded).
    task automatic push(input logic [15:0] d);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) tb_check("push_timeout", 32'(n), 32'd0);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input int addr, input int exp);
        bus.rd_addr = 7'(addr);
        step();
        tb_check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic release_bank();
        bus.product_rdy = 1'b1;
        bus.rd_addr     = 7'd64;
        step();
        bus.product_rdy = 1'b0;
        bus.rd_addr     = 7'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.rd_addr     = '0;
        bus.product_rdy = 1'b0;

        // Reset state
        step(); step(); step();
        tb_check("rst_buffer_rdy", 32'(bus.buffer_rdy), 32'd0);
        tb_check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        tb_check("rst_full_banks", 32'(bus.full_banks), 32'd0);
        tb_check("rst_rd_data",    32'(bus.rd_data),    32'd0);
        reset = 1'b1;
        step();

        // 1: fill bank 0 with 0..63
        for (int i = 0; i < 63; i++) push(16'(i));
        tb_check("t1_rdy_before_last", 32'(bus.buffer_rdy), 32'd0);
        push(16'd63);
        tb_check("t1_buffer_rdy", 32'(bus.buffer_rdy), 32'd1);
        tb_check("t1_full_banks", 32'(bus.full_banks), 32'd1);
        rd("t1_rd0",  0,  0);
        rd("t1_rd17", 17, 17);
        rd("t1_rd63", 63, 63);

        // 2: controller sweep 0..64, release at 64
        for (int a = 0; a < 64; a++) rd("t2_rd", a, a);
        tb_check("t2_rdy_held", 32'(bus.buffer_rdy), 32'd1);
        bus.product_rdy = 1'b1;
        bus.rd_addr     = 7'd64;
        step();
        bus.product_rdy = 1'b0;
        bus.rd_addr     = 7'd0;
        tb_check("t2_rd64_zero",    32'(bus.rd_data),    32'd0);
        tb_check("t2_rdy_low",      32'(bus.buffer_rdy), 32'd0);
        tb_check("t2_full_banks_0", 32'(bus.full_banks), 32'd0);
        step();
        tb_check("t2_rdy_stays_low", 32'(bus.buffer_rdy), 32'd0);

        // 3: fill both banks (bank1 = 0..63, bank0 = 64..127)
        for (int i = 0; i < 128; i++) push(16'(i));
        tb_check("t3_in_ready_0",   32'(bus.in_ready),   32'd0);
        tb_check("t3_full_banks_2", 32'(bus.full_banks), 32'd2);
        tb_check("t3_buffer_rdy",   32'(bus.buffer_rdy), 32'd1);
        rd("t3_first_rd0",  0,  0);
        rd("t3_first_rd63", 63, 63);
        release_bank();
        tb_check("t3_rel_rdy_low",  32'(bus.buffer_rdy), 32'd0);
        tb_check("t3_rel_in_ready", 32'(bus.in_ready),   32'd1);
        tb_check("t3_rel_full_1",   32'(bus.full_banks), 32'd1);
        tb_check("t3_rel_rd64",     32'(bus.rd_data),    32'd0);
        step();
        tb_check("t3_rdy_back",  32'(bus.buffer_rdy), 32'd1);
        tb_check("t3_second_rd0", 32'(bus.rd_data), 32'd64);
        rd("t3_second_rd63", 63, 127);

        // 4: last word of bank1 and release of bank0 in the same cycle
        for (int i = 0; i < 63; i++) push(16'(200 + i));
        tb_check("t4_in_ready_pre", 32'(bus.in_ready), 32'd1);
        bus.in_valid    = 1'b1;
        bus.in_data     = 16'd263;
        bus.product_rdy = 1'b1;
        bus.rd_addr     = 7'd64;
        step();
        bus.in_valid    = 1'b0;
        bus.product_rdy = 1'b0;
        bus.rd_addr     = 7'd0;
        tb_check("t4_full_stays_1", 32'(bus.full_banks), 32'd1);
        tb_check("t4_rdy_low",      32'(bus.buffer_rdy), 32'd0);
        step();
        tb_check("t4_rdy_back", 32'(bus.buffer_rdy), 32'd1);
        tb_check("t4_rd0",      32'(bus.rd_data),    32'd200);
        rd("t4_rd63", 63, 263);

        // 5: reset mid-fill with a full bank pending
        for (int i = 0; i < 30; i++) push(16'(500 + i));
        tb_check("t5_rdy_before", 32'(bus.buffer_rdy), 32'd1);
        rd("t5_rd5", 5, 205);
        #2;
        reset = 1'b0;
        #1;
        tb_check("t5_rst_buffer_rdy", 32'(bus.buffer_rdy), 32'd0);
        tb_check("t5_rst_in_ready",   32'(bus.in_ready),   32'd1);
        tb_check("t5_rst_full_banks", 32'(bus.full_banks), 32'd0);
        tb_check("t5_rst_rd_data",    32'(bus.rd_data),    32'd0);
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 64; i++) push(16'(100 + i));
        tb_check("t5_rdy_after", 32'(bus.buffer_rdy), 32'd1);
        tb_check("t5_full_1",    32'(bus.full_banks), 32'd1);
        rd("t5_rd0",  0,  100);
        rd("t5_rd40", 40, 140);
        rd("t5_rd63", 63, 163);

        // 6: held word while stalled, product_rdy while buffer_rdy=0
        for (int i = 0; i < 64; i++) push(16'(300 + i));
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd999;
        for (int c = 0; c < 3; c++) begin
            step();
            tb_check("t6_stall_in_ready", 32'(bus.in_ready),   32'd0);
            tb_check("t6_stall_full_2",   32'(bus.full_banks), 32'd2);
        end
        bus.product_rdy = 1'b1;
        bus.rd_addr     = 7'd64;
        step();
        tb_check("t6_rel_rdy_low",  32'(bus.buffer_rdy), 32'd0);
        tb_check("t6_rel_full_1",   32'(bus.full_banks), 32'd1);
        tb_check("t6_rel_in_ready", 32'(bus.in_ready),   32'd1);
        // product_rdy still high while buffer_rdy=0; held word now accepted
        step();
        bus.in_valid    = 1'b0;
        bus.product_rdy = 1'b0;
        tb_check("t6_ignored_full_1", 32'(bus.full_banks), 32'd1);
        tb_check("t6_ignored_rdy",    32'(bus.buffer_rdy), 32'd1);
        rd("t6_b1_rd0",  0,  300);
        rd("t6_b1_rd63", 63, 363);
        for (int i = 0; i < 63; i++) push(16'(1000 + i));
        tb_check("t6_full_2",     32'(bus.full_banks), 32'd2);
        tb_check("t6_in_ready_0", 32'(bus.in_ready),   32'd0);
        release_bank();
        step();
        tb_check("t6_held_word", 32'(bus.rd_data), 32'd999);
        rd("t6_b0_rd1",  1,  1000);
        rd("t6_b0_rd63", 63, 1062);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
